strip_scheduler: RTL

STRIP_SCHEDULER -- requirements
Module: strip_scheduler

---
 rtl/strip_scheduler_pkg.sv | 30 +++
 rtl/strip_addr_gen.sv | 109 ++++++++++
 rtl/strip_scheduler.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/strip_scheduler_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | strip_scheduler_pkg                                                 |
// | Shared ISP types and constants for the strip scheduler.             |
// | Revision: 1.0                                                       |
// +---------------------------------------------------------------------+
package strip_scheduler_pkg;

   localparam int COLOR_DEPTH   = 8;
   localparam int COLOR_BIT_CNT = 2;
   localparam int ADDR_W        = 22;

   localparam logic [COLOR_BIT_CNT-1:0] RED   = 2'd0;
   localparam logic [COLOR_BIT_CNT-1:0] GREEN = 2'd1;
   localparam logic [COLOR_BIT_CNT-1:0] BLUE  = 2'd2;
   localparam logic [COLOR_BIT_CNT-1:0] VOID  = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   // Height must leave whole 4-row strips after the 2-row overlap.
   function automatic logic cfg_valid(input logic [9:0] width, input logic [9:0] height);
      return (width >= 10'd3) && (height >= 10'd6) && (height[1:0] == 2'd2);
   endfunction

endpackage
`default_nettype wire

// File: rtl/strip_addr_gen.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | strip_addr_gen                                                      |
// | Beat counters and incremental frame-buffer address generation.      |
// | Revision: 1.0                                                       |
// +---------------------------------------------------------------------+
module strip_addr_gen
   import strip_scheduler_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     load,
   input  logic [9:0]               width,
   input  logic [9:0]               height,
   input  logic                     advance,
   output logic [ADDR_W-1:0]        addr,
   output logic [COLOR_BIT_CNT-1:0] color,
   output logic                     last_col,
   output logic                     last_pic,
   output logic                     last_beat
);

   localparam logic [ADDR_W-1:0] c_three = ADDR_W'(3);

   logic [7:0]               r_strip;
   logic [9:0]               r_col;
   logic [2:0]               r_row;
   logic [COLOR_BIT_CNT-1:0] r_color;
   logic [9:0]               r_last_col;
   logic [7:0]               r_last_strip;
   logic [ADDR_W-1:0]        r_w3;
   logic [ADDR_W-1:0]        r_w9;
   logic [ADDR_W-1:0]        r_col_base;
   logic [ADDR_W-1:0]        r_pix_base;
   logic [ADDR_W-1:0]        r_addr;

   logic w_at_last_col;
   logic w_at_last_strip;
   logic w_row_end;
   logic w_color_end;

   assign w_at_last_col   = (r_col == r_last_col);
   assign w_at_last_strip = (r_strip == r_last_strip);
   assign w_row_end       = (r_row == 3'd5);
   assign w_color_end     = (r_color == BLUE);

   assign addr      = r_addr;
   assign color     = r_color;
   assign last_col  = w_at_last_col;
   assign last_pic  = w_at_last_col && w_at_last_strip;
   assign last_beat = w_at_last_col && w_at_last_strip && w_row_end && w_color_end;

   // r_pix_base tracks ((row*W)+col)*3 for colour 0; r_col_base the same for the strip's first row.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_strip      <= '0;
         r_col        <= '0;
         r_row        <= '0;
         r_color      <= RED;
         r_last_col   <= '0;
         r_last_strip <= '0;
         r_w3         <= '0;
         r_w9         <= '0;
         r_col_base   <= '0;
         r_pix_base   <= '0;
         r_addr       <= '0;
      end else if (load) begin
         r_strip      <= '0;
         r_col        <= '0;
         r_row        <= '0;
         r_color      <= RED;
         r_last_col   <= width - 10'd1;
         r_last_strip <= 8'((height - 10'd6) >> 2);
         r_w3         <= (ADDR_W'(width) << 1) + ADDR_W'(width);
         r_w9         <= (ADDR_W'(width) << 3) + ADDR_W'(width);
         r_col_base   <= '0;
         r_pix_base   <= '0;
         r_addr       <= '0;
      end else if (advance) begin
         if (!w_color_end) begin
            r_color <= r_color + 2'd1;
            r_addr  <= r_addr + ADDR_W'(1);
         end else if (!w_row_end) begin
            r_color    <= RED;
            r_row      <= r_row + 3'd1;
            r_pix_base <= r_pix_base + r_w3;
            r_addr     <= r_pix_base + r_w3;
         end else if (!w_at_last_col) begin
            r_color    <= RED;
            r_row      <= '0;
            r_col      <= r_col + 10'd1;
            r_col_base <= r_col_base + c_three;
            r_pix_base <= r_col_base + c_three;
            r_addr     <= r_col_base + c_three;
         end else begin
            // Next strip starts 4 rows below this strip's first row: +12W from column 0.
            r_color    <= RED;
            r_row      <= '0;
            r_col      <= '0;
            r_strip    <= r_strip + 8'd1;
            r_col_base <= r_col_base + r_w9 + c_three;
            r_pix_base <= r_col_base + r_w9 + c_three;
            r_addr     <= r_col_base + r_w9 + c_three;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/strip_scheduler.sv
`default_nettype none
// +---------------------------------------------------------------------+
// | strip_scheduler                                                     |
// | Reads a frame as overlapping 6-row strips and feeds the denoiser.   |
// | Revision: 1.0                                                       |
// +---------------------------------------------------------------------+
module strip_scheduler
   import strip_scheduler_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     abort,
   input  logic [9:0]               cfg_width,
   input  logic [9:0]               cfg_height,
   output logic                     rd_req,
   output logic [ADDR_W-1:0]        rd_addr,
   input  logic                     rd_gnt,
   input  logic [COLOR_DEPTH-1:0]   rd_data,
   output logic [COLOR_DEPTH-1:0]   pixel_out,
   output logic                     valid_out,
   output logic [COLOR_BIT_CNT-1:0] color_out,
   output logic                     last_col_out,
   output logic                     last_pic_out,
   output logic                     busy,
   output logic                     done,
   output logic                     cfg_err
);

   state_t                   r_state;
   logic                     r_s1_valid;
   logic [COLOR_BIT_CNT-1:0] r_s1_color;
   logic                     r_s1_last_col;
   logic                     r_s1_last_pic;
   logic                     r_s1_last_beat;
   logic                     r_last_beat_out;

   logic [ADDR_W-1:0]        w_gen_addr;
   logic [COLOR_BIT_CNT-1:0] w_gen_color;
   logic                     w_gen_last_col;
   logic                     w_gen_last_pic;
   logic                     w_gen_last_beat;
   logic                     w_cfg_ok;
   logic                     w_load;
   logic                     w_beat;
   logic                     w_kill;
   logic                     w_out_ok;

   assign w_cfg_ok = cfg_valid(cfg_width, cfg_height);
   assign w_load   = (r_state == ST_IDLE) && start && !abort && w_cfg_ok;
   assign w_beat   = (r_state == ST_RUN) && rd_req && rd_gnt && !abort;
   assign w_kill   = abort && (r_state != ST_IDLE);
   assign w_out_ok = r_s1_valid && !w_kill;
   assign rd_addr  = w_gen_addr;

   strip_addr_gen u_addr_gen (
      .clk       (clk),
      .rst       (rst),
      .load      (w_load),
      .width     (cfg_width),
      .height    (cfg_height),
      .advance   (w_beat),
      .addr      (w_gen_addr),
      .color     (w_gen_color),
      .last_col  (w_gen_last_col),
      .last_pic  (w_gen_last_pic),
      .last_beat (w_gen_last_beat)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state         <= ST_IDLE;
         rd_req          <= 1'b0;
         busy            <= 1'b0;
         done            <= 1'b0;
         cfg_err         <= 1'b0;
         r_s1_valid      <= 1'b0;
         r_s1_color      <= VOID;
         r_s1_last_col   <= 1'b0;
         r_s1_last_pic   <= 1'b0;
         r_s1_last_beat  <= 1'b0;
         valid_out       <= 1'b0;
         pixel_out       <= '0;
         color_out       <= VOID;
         last_col_out    <= 1'b0;
         last_pic_out    <= 1'b0;
         r_last_beat_out <= 1'b0;
      end else begin
         done    <= 1'b0;
         cfg_err <= 1'b0;

         // Stage 1 captures the granted beat; rd_data arrives during that stage.
         r_s1_valid     <= w_beat;
         r_s1_color     <= w_beat ? w_gen_color : VOID;
         r_s1_last_col  <= w_beat && w_gen_last_col;
         r_s1_last_pic  <= w_beat && w_gen_last_pic;
         r_s1_last_beat <= w_beat && w_gen_last_beat;

         valid_out       <= w_out_ok;
         color_out       <= w_out_ok ? r_s1_color : VOID;
         last_col_out    <= w_out_ok && r_s1_last_col;
         last_pic_out    <= w_out_ok && r_s1_last_pic;
         r_last_beat_out <= w_out_ok && r_s1_last_beat;
         if (r_s1_valid) begin
            pixel_out <= rd_data;
         end

         case (r_state)
            ST_IDLE: begin
               if (start && !abort) begin
                  if (w_cfg_ok) begin
                     r_state <= ST_RUN;
                     rd_req  <= 1'b1;
                     busy    <= 1'b1;
                  end else begin
                     cfg_err <= 1'b1;
                  end
               end
            end
            ST_RUN: begin
               if (abort) begin
                  r_state <= ST_IDLE;
                  rd_req  <= 1'b0;
                  busy    <= 1'b0;
               end else if (w_beat && w_gen_last_beat) begin
                  r_state <= ST_DRAIN;
                  rd_req  <= 1'b0;
               end
            end
            ST_DRAIN: begin
               if (abort) begin
                  r_state <= ST_IDLE;
                  busy    <= 1'b0;
               end else if (valid_out && r_last_beat_out) begin
                  r_state <= ST_IDLE;
                  busy    <= 1'b0;
                  done    <= 1'b1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               rd_req  <= 1'b0;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
